// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold / shift right / shift left / parallel load,
// with serial cascade ports and a saturating shift-in counter. Define UNIV_REG_ROTATE_EN for the Rotate port.
module universal_shift_register #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerInR,
    input  logic             SerInL,
`ifdef UNIV_REG_ROTATE_EN
    input  logic             Rotate,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             SerOutR,
    output logic             SerOutL,
    output logic [CW-1:0]    Count,
    output logic             Full
);

    localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    count_q;
    logic             ser_r_s;
    logic             ser_l_s;

    // Counter advances on every shift regardless of direction and sticks at WIDTH.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        if (c == COUNT_MAX) begin
            r = c;
        end else begin
            r = c + {{(CW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Select the bits entering each end: external serial input, or wrap-around when rotating.
    always_comb begin
`ifdef UNIV_REG_ROTATE_EN
        ser_r_s = Rotate ? q_q[0]       : SerInR;
        ser_l_s = Rotate ? q_q[WIDTH-1] : SerInL;
`else
        ser_r_s = SerInR;
        ser_l_s = SerInL;
`endif
    end

    // Next-state selection by operating mode.
    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        case (Mode)
            2'b00: begin
                q_d     = q_q;
                count_d = count_q;
            end
            2'b01: begin
                q_d     = {ser_r_s, q_q[WIDTH-1:1]};
                count_d = sat_inc(count_q);
            end
            2'b10: begin
                q_d     = {q_q[WIDTH-2:0], ser_l_s};
                count_d = sat_inc(count_q);
            end
            2'b11: begin
                q_d     = D;
                count_d = {CW{1'b0}};
            end
            default: begin
                q_d     = q_q;
                count_d = count_q;
            end
        endcase
    end

    // State registers; Reset overrides every mode.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_q     <= {WIDTH{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
        end
    end

    // Remaining outputs are pure decodes of the registered state.
    assign Q       = q_q;
    assign Qb      = ~q_q;
    assign SerOutR = q_q[0];
    assign SerOutL = q_q[WIDTH-1];
    assign Count   = count_q;
    assign Full    = (count_q == COUNT_MAX);

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH = 8): arithmetic reference model
// compared every cycle, plus hand-computed expectations. Rotate tests need UNIV_REG_ROTATE_EN.
module tb_universal_shift_register;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         sin_r;
    logic         sin_l;
    logic         rot;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         sout_r;
    logic         sout_l;
    logic [3:0]   cnt;
    logic         full;

    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    int m_q   = 0;
    int m_cnt = 0;

    universal_shift_register #(.WIDTH(W)) dut (
        .Clock   (clk),
        .Reset   (rst),
        .Mode    (mode),
        .D       (d),
        .SerInR  (sin_r),
        .SerInL  (sin_l),
`ifdef UNIV_REG_ROTATE_EN
        .Rotate  (rot),
`endif
        .Q       (q),
        .Qb      (qb),
        .SerOutR (sout_r),
        .SerOutL (sout_l),
        .Count   (cnt),
        .Full    (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the register value and shift count.
    task automatic model_update(input bit r, input int md, input int dv, input bit sr, input bit sl, input bit rt);
        int inbit;
        bit use_rot;
`ifdef UNIV_REG_ROTATE_EN
        use_rot = rt;
`else
        use_rot = 1'b0;
`endif
        if (r) begin
            m_q   = 0;
            m_cnt = 0;
        end else if (md == 1) begin
            inbit = use_rot ? (m_q % 2) : int'(sr);
            m_q   = (m_q / 2) + inbit * 128;
            m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
        end else if (md == 2) begin
            inbit = use_rot ? (m_q / 128) : int'(sl);
            m_q   = ((m_q * 2) % 256) + inbit;
            m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
        end else if (md == 3) begin
            m_q   = dv;
            m_cnt = 0;
        end
    endtask

    task automatic step(input bit r, input int md, input int dv, input bit sr, input bit sl, input bit rt);
        rst   = r;
        mode  = 2'(md);
        d     = 8'(dv);
        sin_r = sr;
        sin_l = sl;
        rot   = rt;
        @(posedge clk);
        model_update(r, md, dv, sr, sl, rt);
        check_en = 1'b1;
        #2;
        // scramble inputs mid-cycle; Q must not move until the next edge
        d     = ~d;
        sin_r = ~sin_r;
        sin_l = ~sin_l;
        @(negedge clk);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_q",       int'(q),      m_q);
            chk("model_qb",      int'(qb),     255 - m_q);
            chk("model_serout_r", int'(sout_r), m_q % 2);
            chk("model_serout_l", int'(sout_l), m_q / 128);
            chk("model_count",   int'(cnt),    m_cnt);
            chk("model_full",    int'(full),   (m_cnt == W) ? 1 : 0);
        end
    end

    int stream [8] = '{1, 0, 1, 1, 0, 0, 1, 0};

    initial begin
        rst = 1'b1; mode = 2'b11; d = 8'hFF; sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3, 8'hFF, 1'b1, 1'b1, 1'b0);
            chk("reset_q",     int'(q),    8'h00);
            chk("reset_qb",    int'(qb),   8'hFF);
            chk("reset_count", int'(cnt),  0);
            chk("reset_full",  int'(full), 0);
        end

        step(1'b0, 3, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("load_q", int'(q), 8'hA5);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b0);
            chk("hold_q",     int'(q),   8'hA5);
            chk("hold_qb",    int'(qb),  8'h5A);
            chk("hold_count", int'(cnt), 0);
        end

        step(1'b0, 1, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("shr_q", int'(q), 8'hD2);
        chk("shr_count", int'(cnt), 1);
        step(1'b0, 2, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("shl_q", int'(q), 8'hA4);
        chk("shl_count", int'(cnt), 2);

        step(1'b1, 0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1, 8'h00, stream[i][0], 1'b0, 1'b0);
            chk("stream_full", int'(full), (i == 7) ? 1 : 0);
        end
        chk("stream_q", int'(q), 8'h4D);
        chk("stream_count", int'(cnt), 8);
        step(1'b0, 1, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("sat_q", int'(q), 8'hA6);
        chk("sat_count", int'(cnt), 8);
        chk("sat_full", int'(full), 1);
        step(1'b0, 3, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("load_clears_full", int'(full), 0);
        chk("load_clears_count", int'(cnt), 0);

        step(1'b1, 0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step((i == 3), 1, 8'h00, 1'b1, 1'b0, 1'b0);
            if (i == 2) chk("midrst_pre_q", int'(q), 8'hE0);
            if (i == 3) begin
                chk("midrst_q", int'(q), 8'h00);
                chk("midrst_count", int'(cnt), 0);
            end
            if (i == 4) begin
                chk("resume_q", int'(q), 8'h80);
                chk("resume_count", int'(cnt), 1);
            end
        end

        // mixed directions still saturate the count
        step(1'b0, 3, 8'h0F, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i % 2 == 0) ? 2 : 1, 8'h00, i[1], i[0], 1'b0);
        end
        chk("mixed_count", int'(cnt), 8);
        step(1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("mixed_hold_full", int'(full), 1);

        step(1'b1, 3, 8'hFF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("release_load_q", int'(q), 8'h5A);

`ifdef UNIV_REG_ROTATE_EN
        step(1'b0, 3, 8'h81, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("rot_r_q", int'(q), 8'hC0);
        chk("rot_r_count", int'(cnt), 1);
        step(1'b0, 2, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("rot_l_q", int'(q), 8'h81);
        chk("rot_l_count", int'(cnt), 2);
        step(1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("rot_hold_q", int'(q), 8'h81);
        step(1'b0, 3, 8'h42, 1'b1, 1'b1, 1'b1);
        chk("rot_load_q", int'(q), 8'h42);
`endif

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised successor to the single-bit rising-edge D flip-flop: a WIDTH-bit register with synchronous active-high reset, four operating modes (hold, shift right, shift left, parallel load), serial cascade ports and a saturating shift-in counter with a Full flag. It is the team's general storage/serialisation element for deserialisers, serial links and multi-bit pipeline registers. It keeps the flip-flop's complementary Q/Qb outputs and its reset-dominates-data semantics.

## Interface
- WIDTH, 8, register width in bits; legal range ≥ 2.
- CW, $clog2(WIDTH+1), counter width (derived, not overridden).

- Clock  input  1  rising-edge clock; all state changes only on this edge.
- Reset  input  1  synchronous, active-high reset; highest priority.
- Mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- D  input  WIDTH  parallel load data.
- SerInR  input  1  bit entering Q[WIDTH-1] on shift right.
- SerInL  input  1  bit entering Q[0] on shift left.
- Rotate  input  1  present only with UNIV_REG_ROTATE_EN; see Configuration.
- Q  output  WIDTH  register contents.
- Qb  output  WIDTH  bitwise complement of Q, always ~Q.
- SerOutR  output  1  Q[0], the bit leaving on a right shift.
- SerOutL  output  1  Q[WIDTH-1], the bit leaving on a left shift.
- Count  output  CW  serial bits shifted in since last load/reset, saturating at WIDTH.
- Full  output  1  high when Count == WIDTH.

## Operation
- One clock, Clock. Reset is synchronous and active-high, sampled on the rising edge.
- Priority at each rising edge: Reset > Mode.
- Reset: Q = 0, Qb = all ones, Count = 0, Full = 0. SerOutR = SerOutL = 0. Mode, D and serial inputs are ignored.
- Mode 00 (hold): Q and Count unchanged.
- Mode 01 (shift right): Q <= {SerInR, Q[WIDTH-1:1]}; Count <= min(Count+1, WIDTH).
- Mode 10 (shift left): Q <= {Q[WIDTH-2:0], SerInL}; Count <= min(Count+1, WIDTH).
- Mode 11 (load): Q <= D; Count <= 0.
- Full is a registered-state decode, Count == WIDTH. It is not a separate flop.
- Qb, SerOutR and SerOutL are combinational decodes of Q. They carry no extra state.
- Count saturation: at Count == WIDTH, further shifts still move data, and Count stays at WIDTH.
- Shift direction does not affect Count. Mixed right and left shifts all increment it.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on Q, Count and Full after edge N. Decoded outputs follow with no extra cycle.
- Between edges, Q is stable regardless of input changes.
- Reset asserted mid-sequence, for example during a shift burst, clears everything on that edge. The first post-reset operation applies on the first edge with Reset low.
- Reset released and Mode = 11 on the same edge: load takes effect on that edge.
- Full rises on the edge of the WIDTH-th shift after a load/reset. It falls only on load or Reset.

## Configuration
- Macro: UNIV_REG_ROTATE_EN.
- Defined: port Rotate exists.
  - Rotate = 1 in mode 01: Q <= {Q[0], Q[WIDTH-1:1]}.
  - Rotate = 1 in mode 10: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - Serial inputs are ignored while rotating.
  - Count still increments, with the same saturation.
  - Rotate is ignored in modes 00, 11 and under Reset.
- Undefined: no Rotate port; shifts always use SerInR/SerInL.

## Test plan
- Reset held 5 cycles with D = 8'hFF, Mode = 11 -> Q = 8'h00, Qb = 8'hFF, Count = 0, Full = 0 throughout.
- Load D = 8'hA5 (Mode 11) then hold 3 cycles -> Q = 8'hA5, Qb = 8'h5A, Count = 0 for all 4 cycles.
- From Q = 8'hA5, one right shift with SerInR = 1 -> Q = 8'hD2, Count = 1. Then one left shift with SerInL = 0 -> Q = 8'hA4, Count = 2.
- After reset, 8 right shifts of serial stream 1,0,1,1,0,0,1,0 (first bit first) -> Q = 8'h4D, Full rises exactly on the 8th edge. A 9th shift keeps Count = 8 and Full = 1. A subsequent load clears Full.
- Reset asserted on the 4th of 8 shifts -> Q = 0, Count = 0 on that edge. Shifts resume from 0 next edge.
- With UNIV_REG_ROTATE_EN: load 8'h81, Rotate = 1, one right shift -> Q = 8'hC0. Then one left shift -> Q = 8'h81. SerInR/SerInL toggling has no effect.
